// File: rtl/theia_host_ctrl_pkg.sv
// Shared definitions for the Theia host controller: default geometry and FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package theia_host_ctrl_pkg;

  localparam int DEF_WB_WIDTH       = 32;
  localparam int DEF_MAX_CORES      = 8;
  localparam int DEF_MAX_CORE_BITS  = 3;
  localparam int DEF_MAX_TMEM_BANKS = 8;
  localparam int DEF_TMEM_BANK_BITS = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TLOAD  = 3'd1,
    ST_SIGNAL = 3'd2,
    ST_RENDER = 3'd3,
    ST_GACK   = 3'd4,
    ST_READ   = 3'd5,
    ST_FIN    = 3'd6
  } hostState_t;

endpackage

// File: rtl/theia_omem_reader.sv
// Output-memory readback walker: bank-major, address-minor sweep streamed out as valid/ready.
// Latency: a word appears on rdDat one cycle after its address is driven on bankSel/addr.
// Backpressure: rdRdy low holds rdDat/rdVld and the address; a one-entry skid keeps the in-flight word.
// Ports: clk/rstN; start (arm one sweep), omLen (words per bank); bankSel/addr/omemData to the memory;
//        rdDat/rdVld/rdRdy readback stream; done pulses with the handshake of the final word.
module theia_omem_reader
  import theia_host_ctrl_pkg::*;
#(
  parameter int WB_WIDTH      = DEF_WB_WIDTH,
  parameter int MAX_CORES     = DEF_MAX_CORES,
  parameter int MAX_CORE_BITS = DEF_MAX_CORE_BITS
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     start,
  input  logic [WB_WIDTH-1:0]      omLen,
  output logic [MAX_CORE_BITS-1:0] bankSel,
  output logic [WB_WIDTH-1:0]      addr,
  input  logic [WB_WIDTH-1:0]      omemData,
  output logic [WB_WIDTH-1:0]      rdDat,
  output logic                     rdVld,
  input  logic                     rdRdy,
  output logic                     done
);

  logic                active;    // addresses still to issue
  logic                draining;  // final address issued, waiting for its handshake
  logic                pipeVld;   // address issued last cycle, its data is on omemData now
  logic                skVld;
  logic [WB_WIDTH-1:0] skDat;
  logic                issue;
  logic                lastAddr;

  assign rdVld    = skVld | pipeVld;
  assign rdDat    = skVld ? skDat : (pipeVld ? omemData : '0);
  // Only issue when the word now on the output leaves this cycle, so at most one word is ever in flight.
  assign issue    = active && (!rdVld || rdRdy);
  assign lastAddr = (bankSel == MAX_CORE_BITS'(MAX_CORES - 1)) && (addr == omLen - WB_WIDTH'(1));
  assign done     = draining && rdVld && rdRdy;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      active   <= 1'b0;
      draining <= 1'b0;
      pipeVld  <= 1'b0;
      skVld    <= 1'b0;
      skDat    <= '0;
      bankSel  <= '0;
      addr     <= '0;
    end else if (done) begin
      active   <= 1'b0;
      draining <= 1'b0;
      pipeVld  <= 1'b0;
      skVld    <= 1'b0;
      skDat    <= '0;
      bankSel  <= '0;
      addr     <= '0;
    end else begin
      if (start) active <= 1'b1;
      if (issue) begin
        // Hold the final address rather than stepping the bank past the last core.
        if (lastAddr) begin
          active   <= 1'b0;
          draining <= 1'b1;
        end else if (addr == omLen - WB_WIDTH'(1)) begin
          addr    <= '0;
          bankSel <= bankSel + MAX_CORE_BITS'(1);
        end else begin
          addr <= addr + WB_WIDTH'(1);
        end
      end
      pipeVld <= issue;
      // The memory re-reads whatever address is presented, so a stalled word must be captured now.
      if (pipeVld && !rdRdy && !skVld) begin
        skVld <= 1'b1;
        skDat <= omemData;
      end else if (skVld && rdRdy) begin
        skVld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/theia_host_ctrl.sv
// Theia host frame sequencer: texture load, scene signal, render gating, GPU ack, output readback.
// Latency: texture writes are combinational from the stream beat; readback words trail their address by one cycle.
// Backpressure: TXRDY_O is high throughout texture load; RDRDY_I low stalls the readback without loss.
// Ports: CLK_I/RST_I; START_I with TXLEN_I/OMLEN_I; TX* texture stream in; TM* texture memory write;
//        RENDREN_O/STDONE_O/HDA_O/GACK_O/DONE_I core handshake; OM* output memory; RD* readback; BUSY_O/FRAME_DONE_O.
module theia_host_ctrl
  import theia_host_ctrl_pkg::*;
#(
  parameter int WB_WIDTH       = DEF_WB_WIDTH,
  parameter int MAX_CORES      = DEF_MAX_CORES,
  parameter int MAX_CORE_BITS  = DEF_MAX_CORE_BITS,
  parameter int MAX_TMEM_BANKS = DEF_MAX_TMEM_BANKS,
  parameter int TMEM_BANK_BITS = DEF_TMEM_BANK_BITS
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic                      START_I,
  input  logic [WB_WIDTH-1:0]       TXLEN_I,
  input  logic [WB_WIDTH-1:0]       OMLEN_I,
  input  logic [WB_WIDTH-1:0]       TXDAT_I,
  input  logic                      TXVLD_I,
  output logic                      TXRDY_O,
  output logic [WB_WIDTH-1:0]       TMDAT_O,
  output logic [WB_WIDTH-1:0]       TMADR_O,
  output logic                      TMWE_O,
  output logic [MAX_TMEM_BANKS-1:0] TMSEL_O,
  output logic [MAX_CORES-1:0]      RENDREN_O,
  output logic                      STDONE_O,
  output logic                      HDA_O,
  output logic                      GACK_O,
  input  logic                      GRDY_I,
  input  logic                      RCOMMIT_I,
  input  logic                      DONE_I,
  output logic [MAX_CORE_BITS-1:0]  OMBSEL_O,
  output logic [WB_WIDTH-1:0]       OMADR_O,
  input  logic [WB_WIDTH-1:0]       OMEM_I,
  output logic [WB_WIDTH-1:0]       RDDAT_O,
  output logic                      RDVLD_O,
  input  logic                      RDRDY_I,
  output logic                      BUSY_O,
  output logic                      FRAME_DONE_O
);

  hostState_t          state, nextState;
  logic [WB_WIDTH-1:0] txLen, omLen, wordIdx;
  logic                txRdy, tmWe, stDone, hda, gAck, rendEn, frameDone, rdStart, rdDone;
  logic                unusedInfo;

  // GPU ready and render commit are status-only; the sequence does not depend on them.
  assign unusedInfo = &{1'b0, GRDY_I, RCOMMIT_I};

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state   <= ST_IDLE;
      txLen   <= '0;
      omLen   <= '0;
      wordIdx <= '0;
    end else begin
      state <= nextState;
      if (state == ST_IDLE && START_I) begin
        txLen   <= TXLEN_I;
        omLen   <= OMLEN_I;
        wordIdx <= '0;
      end else if (tmWe) begin
        wordIdx <= wordIdx + WB_WIDTH'(1);
      end
    end
  end

  always_comb begin
    nextState = state;
    txRdy     = 1'b0;
    tmWe      = 1'b0;
    stDone    = 1'b0;
    hda       = 1'b0;
    gAck      = 1'b0;
    rendEn    = 1'b0;
    frameDone = 1'b0;
    rdStart   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (START_I) nextState = (TXLEN_I == '0) ? ST_SIGNAL : ST_TLOAD;
      end
      ST_TLOAD: begin
        txRdy = 1'b1;
        if (TXVLD_I) begin
          tmWe = 1'b1;
          if (wordIdx == txLen - WB_WIDTH'(1)) nextState = ST_SIGNAL;
        end
      end
      ST_SIGNAL: begin
        stDone    = 1'b1;
        hda       = 1'b1;
        nextState = ST_RENDER;
      end
      ST_RENDER: begin
        rendEn = 1'b1;
        hda    = 1'b1;
        if (DONE_I) nextState = ST_GACK;
      end
      ST_GACK: begin
        gAck      = 1'b1;
        hda       = 1'b1;
        rdStart   = (omLen != '0);
        nextState = (omLen == '0) ? ST_FIN : ST_READ;
      end
      ST_READ: begin
        if (rdDone) nextState = ST_FIN;
      end
      ST_FIN: begin
        frameDone = 1'b1;
        nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  theia_omem_reader #(
    .WB_WIDTH      (WB_WIDTH),
    .MAX_CORES     (MAX_CORES),
    .MAX_CORE_BITS (MAX_CORE_BITS)
  ) uReader (
    .clk      (CLK_I),
    .rstN     (RST_I),
    .start    (rdStart),
    .omLen    (omLen),
    .bankSel  (OMBSEL_O),
    .addr     (OMADR_O),
    .omemData (OMEM_I),
    .rdDat    (RDDAT_O),
    .rdVld    (RDVLD_O),
    .rdRdy    (RDRDY_I),
    .done     (rdDone)
  );

  // Linear word index splits into low bits = bank, high bits = row within the bank.
  assign TXRDY_O      = txRdy;
  assign TMWE_O       = tmWe;
  assign TMDAT_O      = tmWe ? TXDAT_I : '0;
  assign TMADR_O      = tmWe ? (wordIdx >> TMEM_BANK_BITS) : '0;
  assign TMSEL_O      = tmWe ? MAX_TMEM_BANKS'(wordIdx[TMEM_BANK_BITS-1:0]) : '0;
  assign RENDREN_O    = {MAX_CORES{rendEn}};
  assign STDONE_O     = stDone;
  assign HDA_O        = hda;
  assign GACK_O       = gAck;
  assign BUSY_O       = (state != ST_IDLE);
  assign FRAME_DONE_O = frameDone;

endmodule

// File: tb/tb_theia_host_ctrl.sv
// Randomized scoreboard bench for theia_host_ctrl: driver queues expected events, monitor pops and compares.
// Latency: monitor samples every falling edge; driver changes inputs 1 time unit after the rising edge.
// Backpressure: RDRDY_I is driven always-high, 1-0-0 pattern or random per frame.
module tb_theia_host_ctrl;

  localparam int W   = 32;
  localparam int NC  = 8;
  localparam int NCB = 3;
  localparam int NB  = 8;
  localparam int NBB = 3;

  localparam logic [2:0] K_WR = 3'd1;
  localparam logic [2:0] K_ST = 3'd2;
  localparam logic [2:0] K_GA = 3'd3;
  localparam logic [2:0] K_RD = 3'd4;
  localparam logic [2:0] K_FD = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
  } exp_t;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b0;
  logic          START_I = 1'b0;
  logic [W-1:0]  TXLEN_I = '0;
  logic [W-1:0]  OMLEN_I = '0;
  logic [W-1:0]  TXDAT_I = '0;
  logic          TXVLD_I = 1'b0;
  logic          TXRDY_O;
  logic [W-1:0]  TMDAT_O;
  logic [W-1:0]  TMADR_O;
  logic          TMWE_O;
  logic [NB-1:0] TMSEL_O;
  logic [NC-1:0] RENDREN_O;
  logic          STDONE_O;
  logic          HDA_O;
  logic          GACK_O;
  logic          GRDY_I = 1'b0;
  logic          RCOMMIT_I = 1'b0;
  logic          DONE_I = 1'b0;
  logic [NCB-1:0] OMBSEL_O;
  logic [W-1:0]  OMADR_O;
  logic [W-1:0]  OMEM_I = '0;
  logic [W-1:0]  RDDAT_O;
  logic          RDVLD_O;
  logic          RDRDY_I = 1'b0;
  logic          BUSY_O;
  logic          FRAME_DONE_O;

  theia_host_ctrl #(
    .WB_WIDTH(W), .MAX_CORES(NC), .MAX_CORE_BITS(NCB), .MAX_TMEM_BANKS(NB), .TMEM_BANK_BITS(NBB)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .TXLEN_I(TXLEN_I), .OMLEN_I(OMLEN_I),
    .TXDAT_I(TXDAT_I), .TXVLD_I(TXVLD_I), .TXRDY_O(TXRDY_O), .TMDAT_O(TMDAT_O), .TMADR_O(TMADR_O),
    .TMWE_O(TMWE_O), .TMSEL_O(TMSEL_O), .RENDREN_O(RENDREN_O), .STDONE_O(STDONE_O), .HDA_O(HDA_O),
    .GACK_O(GACK_O), .GRDY_I(GRDY_I), .RCOMMIT_I(RCOMMIT_I), .DONE_I(DONE_I), .OMBSEL_O(OMBSEL_O),
    .OMADR_O(OMADR_O), .OMEM_I(OMEM_I), .RDDAT_O(RDDAT_O), .RDVLD_O(RDVLD_O), .RDRDY_I(RDRDY_I),
    .BUSY_O(BUSY_O), .FRAME_DONE_O(FRAME_DONE_O)
  );

  always #5 CLK_I = ~CLK_I;

  logic anyOut;
  assign anyOut = |{TXRDY_O, TMWE_O, TMDAT_O, TMADR_O, TMSEL_O, RENDREN_O, STDONE_O, HDA_O, GACK_O,
                    OMBSEL_O, OMADR_O, RDDAT_O, RDVLD_O, BUSY_O, FRAME_DONE_O};

  int checks = 0;
  int failures = 0;
  exp_t expQ[$];
  logic [31:0] memSalt = '0;
  int rdyMode = 0;
  int curOmLen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mkExp(input logic [2:0] kind, input int a, input int b, input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.a = 32'(a);
    e.b = 32'(b);
    e.d = d;
    return e;
  endfunction

  // Output memory contents: distinct per (bank, address); salt 0 gives (bank<<8)|addr.
  function automatic logic [31:0] memWord(input int b, input int a);
    return memSalt ^ 32'((b << 8) | a);
  endfunction

  always @(posedge CLK_I) OMEM_I <= memWord(int'(OMBSEL_O), int'(OMADR_O));

  initial begin : rdyDrv
    int ph;
    ph = 0;
    forever begin
      @(posedge CLK_I);
      #1;
      case (rdyMode)
        0: RDRDY_I = 1'b1;
        1: RDRDY_I = (ph % 3 == 0);
        default: RDRDY_I = ($urandom_range(0, 1) == 1);
      endcase
      ph++;
    end
  end

  task automatic popExp(input logic [2:0] kind, output exp_t e);
    e = '0;
    chk("event_expected", 32'(expQ.size() != 0), 32'd1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      chk("event_kind", 32'(e.kind), 32'(kind));
    end
  endtask

  int cyc = 0;
  int lastWrCyc = 0;
  int gackCyc = 0;
  int lastRdCyc = 0;
  int rdBeats = 0;
  bit wrSeen = 0;
  bit stallPrev = 0;
  logic [31:0] heldDat = '0;

  always @(negedge CLK_I) begin : monitor
    exp_t e;
    cyc++;
    if (!RST_I) begin
      expQ.delete();
      wrSeen = 0;
      stallPrev = 0;
      rdBeats = 0;
    end else begin
      if (TMWE_O) begin
        popExp(K_WR, e);
        chk("tm_bank", 32'(TMSEL_O), e.a);
        chk("tm_addr", TMADR_O, e.b);
        chk("tm_data", TMDAT_O, e.d);
        lastWrCyc = cyc;
        wrSeen = 1;
      end
      if (STDONE_O) begin
        popExp(K_ST, e);
        if (wrSeen) chk("stdone_after_last_write", 32'(cyc - lastWrCyc), 32'd1);
      end
      if (GACK_O) begin
        popExp(K_GA, e);
        gackCyc = cyc;
      end
      if (stallPrev) begin
        chk("stall_hold_vld", 32'(RDVLD_O), 32'd1);
        chk("stall_hold_dat", RDDAT_O, heldDat);
      end
      if (RDVLD_O && RDRDY_I) begin
        popExp(K_RD, e);
        chk("rd_data", RDDAT_O, e.d);
        if (rdyMode == 0 && rdBeats > 0) chk("rd_back_to_back", 32'(cyc - lastRdCyc), 32'd1);
        rdBeats++;
        lastRdCyc = cyc;
      end
      stallPrev = RDVLD_O && !RDRDY_I;
      heldDat = RDDAT_O;
      if (FRAME_DONE_O) begin
        popExp(K_FD, e);
        if (curOmLen == 0) chk("fdone_after_gack", 32'(cyc - gackCyc), 32'd1);
        wrSeen = 0;
        rdBeats = 0;
      end
    end
  end

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic runFrame(input int txLen, input int omLen, input int vldMode, input int rMode,
                          input logic [31:0] salt, input bit startInRender, input int abortBeat);
    logic [31:0] txData[$];
    int idx;
    int guard;
    bit hs;
    memSalt = salt;
    rdyMode = rMode;
    curOmLen = omLen;
    for (int k = 0; k < txLen; k++) begin
      txData.push_back($urandom);
      expQ.push_back(mkExp(K_WR, k % NB, k / NB, txData[k]));
    end
    expQ.push_back(mkExp(K_ST, 0, 0, '0));
    expQ.push_back(mkExp(K_GA, 0, 0, '0));
    for (int b = 0; b < NC; b++)
      for (int a = 0; a < omLen; a++)
        expQ.push_back(mkExp(K_RD, b, a, memWord(b, a)));
    expQ.push_back(mkExp(K_FD, 0, 0, '0));

    START_I = 1'b1;
    TXLEN_I = 32'(txLen);
    OMLEN_I = 32'(omLen);
    @(posedge CLK_I);
    #1;
    START_I = 1'b0;
    TXLEN_I = $urandom;
    OMLEN_I = $urandom;

    idx = 0;
    guard = 0;
    while (idx < txLen && guard < 2000) begin
      TXVLD_I = (vldMode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      TXDAT_I = TXVLD_I ? txData[idx] : $urandom;
      @(negedge CLK_I);
      hs = TXVLD_I && TXRDY_O;
      @(posedge CLK_I);
      #1;
      if (hs) idx++;
      guard++;
    end
    TXVLD_I = 1'b0;
    if (guard >= 2000) chk("timeout_tload", 32'd0, 32'd1);

    guard = 0;
    while (RENDREN_O !== {NC{1'b1}} && guard < 100) begin
      @(posedge CLK_I);
      #1;
      guard++;
    end
    chk("render_enable", 32'(RENDREN_O), 32'hFF);
    chk("hda_in_render", 32'(HDA_O), 32'd1);
    if (startInRender) begin
      START_I = 1'b1;
      TXLEN_I = 32'd5;
      OMLEN_I = 32'd1;
      @(posedge CLK_I);
      #1;
      START_I = 1'b0;
    end
    repeat ($urandom_range(0, 3)) begin
      @(posedge CLK_I);
      #1;
    end
    DONE_I = 1'b1;
    @(posedge CLK_I);
    #1;
    DONE_I = 1'b0;
    chk("rendren_cleared", 32'(RENDREN_O), 32'd0);

    guard = 0;
    while (BUSY_O && guard < 5000) begin
      if (abortBeat > 0 && rdBeats >= abortBeat) begin
        #2;
        RST_I = 1'b0;
        #1;
        chk("reset_mid_read_outputs_zero", 32'(anyOut), 32'd0);
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        return;
      end
      @(posedge CLK_I);
      #1;
      guard++;
    end
    chk("frame_completes", 32'(guard < 5000), 32'd1);
    chk("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin : driver
    RST_I = 1'b0;
    repeat (3) @(posedge CLK_I);
    #1;
    chk("reset_outputs_zero", 32'(anyOut), 32'd0);
    RST_I = 1'b1;
    runFrame(10, 4, 1, 0, 32'h0, 1'b0, 0);
    runFrame(0, 0, 0, 0, 32'h0, 1'b0, 0);
    runFrame(5, 4, 0, 1, 32'h0, 1'b0, 0);
    runFrame(12, 4, 0, 0, 32'h00AB0000, 1'b0, 17);
    runFrame(3, 2, 0, 0, $urandom, 1'b0, 0);
    runFrame(7, 3, 0, 2, $urandom, 1'b1, 0);
    for (int i = 0; i < 6; i++)
      runFrame($urandom_range(0, 20), $urandom_range(0, 5), $urandom_range(0, 1),
               $urandom_range(0, 2), $urandom, ($urandom_range(0, 1) == 1), 0);
    repeat (3) @(posedge CLK_I);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
